shift_left_seq: RTL and testbench

Sequential multi-cycle left-shift unit for the processor datapath. It is the left-direction counterpart of the combinational right-shift stage: it performs LSL, ROL and RLC by a programmable amount of 0–15 bits, one bit per clock, behind a start/done handshake. The result register and carry out hold stable between operations, so the ALU result mux and flag logic can sample them whenever done pulses.

---
 rtl/shift_left_seq.sv | 117 +++++++++++
 tb/tb_shift_left_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_left_seq.sv
// shift_left_seq: sequential 16-bit left shifter (LSL / ROL / RLC) that
// shifts one bit per clock behind a start/done handshake. Y and C_out are
// result registers. They update only when an operation completes or on reset.
module shift_left_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] A,
   input  logic [1:0]  op,
   input  logic [3:0]  amt,
   input  logic        C_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] Y,
   output logic        C_out
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_ROL  = 2'b01;
   localparam logic [1:0] OP_LSL  = 2'b10;
   localparam logic [1:0] OP_RLC  = 2'b11;

   state_t      state_r;
   logic [15:0] work_r;
   logic        cy_r;
   logic [3:0]  cnt_r;
   logic [1:0]  op_q_r;
   logic [16:0] step_s;   // {carry, work} after one step

   // One single-bit step. Every shift kind moves work[15] into the carry.
   // RLC feeds the old carry into bit 0, so {cy, work} rotates as 17 bits.
   function automatic logic [16:0] shift_step(input logic [1:0]  op_sel,
                                              input logic [15:0] w,
                                              input logic        c);
      logic [16:0] r;
      case (op_sel)
         OP_LSL:  r = {w[15], w[14:0], 1'b0};
         OP_ROL:  r = {w[15], w[14:0], w[15]};
         OP_RLC:  r = {w[15], w[14:0], c};
         default: r = {c, w};
      endcase
      return r;
   endfunction

   // Next {carry, work} value for the current shift step
   always_comb begin
      step_s = 17'd0;
      step_s = shift_step(op_q_r, work_r, cy_r);
   end

   // Control FSM, working registers and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         work_r  <= 16'h0000;
         cy_r    <= 1'b0;
         cnt_r   <= 4'd0;
         op_q_r  <= 2'b00;
         busy    <= 1'b0;
         done    <= 1'b0;
         Y       <= 16'h0000;
         C_out   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= ST_IDLE;
               if (start) begin
                  work_r <= A;
                  cy_r   <= C_in;
                  cnt_r  <= amt;
                  op_q_r <= op;
                  if ((amt == 4'd0) || (op == OP_NONE)) begin
                     // Nothing to shift: the result is the operand itself
                     state_r <= ST_DONE;
                     done    <= 1'b1;
                     Y       <= A;
                     C_out   <= C_in;
                  end else begin
                     state_r <= ST_SHIFT;
                     busy    <= 1'b1;
                  end
               end else begin
                  work_r <= work_r;
               end
            end
            ST_SHIFT: begin
               work_r <= step_s[15:0];
               cy_r   <= step_s[16];
               cnt_r  <= cnt_r - 4'd1;
               if (cnt_r == 4'd1) begin
                  state_r <= ST_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  Y       <= step_s[15:0];
                  C_out   <= step_s[16];
               end else begin
                  state_r <= ST_SHIFT;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_left_seq.sv
// Self-checking bench for shift_left_seq: directed vector table, random
// operations against an arithmetic reference model, and abort/ignore sequences.
module tb_shift_left_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] A;
   logic [1:0]  op;
   logic [3:0]  amt;
   logic        C_in;
   logic        busy;
   logic        done;
   logic [15:0] Y;
   logic        C_out;

   int tests;
   int fails;

   shift_left_seq dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .A     (A),
      .op    (op),
      .amt   (amt),
      .C_in  (C_in),
      .busy  (busy),
      .done  (done),
      .Y     (Y),
      .C_out (C_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [1:0]  o;
      logic [3:0]  n;
      logic        c;
      logic        b2b;
      logic [15:0] exp_y;
      logic        exp_c;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: the shift as a whole, by arithmetic on wide values.
   function automatic logic [16:0] ref_model(input logic [15:0] a, input logic [1:0] o,
                                             input logic [3:0] n, input logic c);
      logic [31:0] l;
      logic [33:0] w;
      logic [16:0] r;
      r = {c, a};
      if (n != 4'd0 && o != 2'b00) begin
         case (o)
            2'b10: begin
               l = {16'h0000, a} << n;
               r = l[16:0];
            end
            2'b01: begin
               l = {a, a} << n;
               r = {l[16], l[31:16]};
            end
            2'b11: begin
               w = {c, a, c, a} << n;
               r = w[33:17];
            end
            default: r = {c, a};
         endcase
      end
      return r;
   endfunction

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation (caller is at #1 after an edge, not in SHIFT).
   // pulse_at > 0 drives an extra start with A=FFFF while shifting.
   task automatic run_op(input string name, input logic [15:0] a, input logic [1:0] o,
                         input logic [3:0] n, input logic c, input int pulse_at);
      logic [16:0] exp;
      logic [15:0] prev_y;
      int          exp_lat;
      int          cycles;
      int          busy_cnt;
      logic        hold_bad;
      exp     = ref_model(a, o, n, c);
      exp_lat = (n == 4'd0 || o == 2'b00) ? 0 : int'(n);
      prev_y  = Y;
      A = a; op = o; amt = n; C_in = c; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A = 16'($urandom); op = 2'($urandom); amt = 4'($urandom); C_in = 1'($urandom);
      cycles = 0; busy_cnt = 0; hold_bad = 1'b0;
      while (!done && cycles < 40) begin
         if (busy) busy_cnt++;
         if (Y !== prev_y) hold_bad = 1'b1;
         if (pulse_at > 0 && cycles + 1 == pulse_at) begin
            start = 1'b1; A = 16'hFFFF;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         cycles++;
      end
      start = 1'b0;
      chk({name, " latency"}, cycles, exp_lat);
      chk({name, " busy_cycles"}, busy_cnt, exp_lat);
      chk({name, " Y"}, {16'h0000, Y}, {16'h0000, exp[15:0]});
      chk({name, " C_out"}, {31'd0, C_out}, {31'd0, exp[16]});
      chk({name, " Y_hold"}, {31'd0, hold_bad}, 32'd0);
   endtask

   initial begin
      logic [15:0] y_save;
      logic        c_save;
      logic        saw_done;
      tests = 0; fails = 0;
      reset = 1'b1; start = 1'b0; A = 16'h0; op = 2'b00; amt = 4'd0; C_in = 1'b0;

      vecs[0] = '{16'h8001, 2'b10, 4'd1,  1'b0, 1'b0, 16'h0002, 1'b1};
      vecs[1] = '{16'h8001, 2'b01, 4'd4,  1'b0, 1'b0, 16'h0018, 1'b0};
      vecs[2] = '{16'h0001, 2'b10, 4'd15, 1'b0, 1'b0, 16'h8000, 1'b0};
      vecs[3] = '{16'h8000, 2'b11, 4'd2,  1'b1, 1'b0, 16'h0003, 1'b0};
      vecs[4] = '{16'hFFFF, 2'b11, 4'd1,  1'b0, 1'b1, 16'hFFFE, 1'b1};
      vecs[5] = '{16'h1234, 2'b10, 4'd0,  1'b1, 1'b0, 16'h1234, 1'b1};
      vecs[6] = '{16'h1234, 2'b00, 4'd15, 1'b1, 1'b0, 16'h1234, 1'b1};

      // Reset: two cycles, then idle
      idle_cycle();
      idle_cycle();
      reset = 1'b0;
      idle_cycle();
      chk("reset Y", {16'h0, Y}, 32'h0);
      chk("reset C_out", {31'd0, C_out}, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);

      // Directed table (b2b entries start during the previous DONE cycle)
      for (int i = 0; i < 7; i++) begin
         if (!vecs[i].b2b) begin
            idle_cycle();
            chk($sformatf("vec%0d done_low", i), {31'd0, done}, 32'd0);
         end
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].o, vecs[i].n, vecs[i].c, 0);
         chk($sformatf("vec%0d tableY", i), {16'h0, Y}, {16'h0, vecs[i].exp_y});
         chk($sformatf("vec%0d tableC", i), {31'd0, C_out}, {31'd0, vecs[i].exp_c});
      end

      // Randomised operations, some back-to-back
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) != 0) begin
            idle_cycle();
            chk($sformatf("rnd%0d done_low", i), {31'd0, done}, 32'd0);
         end
         run_op($sformatf("rnd%0d", i), 16'($urandom), 2'($urandom), 4'($urandom),
                1'($urandom), 0);
      end

      // Start pulse during SHIFT is ignored; original operand is used
      idle_cycle();
      run_op("ignore", 16'h0002, 2'b10, 4'd15, 1'b0, 3);

      // Reset during SHIFT abandons the operation with no done pulse
      idle_cycle();
      A = 16'h0005; op = 2'b10; amt = 4'd15; C_in = 1'b1; start = 1'b1;
      idle_cycle();
      start = 1'b0;
      idle_cycle();
      A = 16'hFFFF; start = 1'b1;
      idle_cycle();
      start = 1'b0;
      chk("abort busy_mid", {31'd0, busy}, 32'd1);
      idle_cycle();
      idle_cycle();
      reset = 1'b1;
      idle_cycle();
      reset = 1'b0;
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort Y", {16'h0, Y}, 32'h0);
      chk("abort C_out", {31'd0, C_out}, 32'd0);
      saw_done = done;
      y_save = Y; c_save = C_out;
      for (int k = 0; k < 25; k++) begin
         idle_cycle();
         if (done) saw_done = 1'b1;
      end
      chk("abort no_done", {31'd0, saw_done}, 32'd0);
      chk("abort Y_hold", {16'h0, Y}, {16'h0, y_save});
      chk("abort C_hold", {31'd0, C_out}, {31'd0, c_save});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
